// File: rtl/stdp_pkg.sv
// Shared types and default constants for the STDP synapse controller.
package stdp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreOpen,
    StPostOpen,
    StUpdate
  } state_e;

  localparam int unsigned W_WIDTH_DEF   = 8;
  localparam int unsigned T_WIDTH_DEF   = 5;
  localparam int unsigned WINDOW_DEF    = 16;
  localparam int unsigned W_INIT_DEF    = 64;
  localparam int unsigned W_MAX_DEF     = 255;
  localparam int unsigned W_MIN_DEF     = 0;
  localparam int unsigned A_PLUS_DEF    = 32;
  localparam int unsigned A_MINUS_DEF   = 32;
  localparam int unsigned TAU_SHIFT_DEF = 2;

endpackage

// File: rtl/stdp_timer.sv
// Saturating spike-interval counter with clear/enable and a window-reached flag.
module stdp_timer #(
  parameter int unsigned T_WIDTH = 5,
  parameter int unsigned WINDOW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [T_WIDTH-1:0] count,
  output logic               at_window
);

  localparam logic [T_WIDTH-1:0] WinVal = T_WIDTH'(WINDOW);

  logic [T_WIDTH-1:0] count_q;

  // The opening spike's cycle counts as 0, so the first cycle after clear reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= T_WIDTH'(1);
    end else if (en && (count_q != WinVal)) begin
      count_q <= count_q + T_WIDTH'(1);
    end
  end

  assign count     = count_q;
  assign at_window = (count_q == WinVal);

endmodule

// File: rtl/stdp_ctrl.sv
// STDP controller: pairs pre/post spikes, applies saturating LTP/LTD to the weight,
// and drives the weighted synaptic current into the postsynaptic neuron.
module stdp_ctrl
  import stdp_pkg::*;
#(
  parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
  parameter int unsigned T_WIDTH   = T_WIDTH_DEF,
  parameter int unsigned WINDOW    = WINDOW_DEF,
  parameter int unsigned W_INIT    = W_INIT_DEF,
  parameter int unsigned W_MAX     = W_MAX_DEF,
  parameter int unsigned W_MIN     = W_MIN_DEF,
  parameter int unsigned A_PLUS    = A_PLUS_DEF,
  parameter int unsigned A_MINUS   = A_MINUS_DEF,
  parameter int unsigned TAU_SHIFT = TAU_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               learn_en,
  input  logic               pre_spike,
  input  logic               post_spike,
  output logic [W_WIDTH-1:0] weight,
  output logic [W_WIDTH-1:0] syn_current,
  output logic               update_valid,
  output logic               ltp,
  output logic [T_WIDTH-1:0] dt,
  output logic               busy
);

  localparam int unsigned WX = W_WIDTH + 1;
  localparam logic [W_WIDTH:0] WMaxX   = WX'(W_MAX);
  localparam logic [W_WIDTH:0] WMinX   = WX'(W_MIN);
  localparam logic [W_WIDTH:0] APlusX  = WX'(A_PLUS);
  localparam logic [W_WIDTH:0] AMinusX = WX'(A_MINUS);

  state_e state_q, state_d;

  logic               timer_clr, timer_en, at_window;
  logic [T_WIDTH-1:0] timer;
  logic               close, close_ltp, do_update;
  logic [T_WIDTH-1:0] pend_dt_q;
  logic               pend_ltp_q;
  logic [W_WIDTH-1:0] weight_q, weight_d, syn_q;
  logic               valid_q, ltp_q;
  logic [T_WIDTH-1:0] dt_q;

  logic [T_WIDTH-1:0] sh;
  logic [W_WIDTH:0]   amp, delta, sum;

  stdp_timer #(
    .T_WIDTH (T_WIDTH),
    .WINDOW  (WINDOW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (timer_clr),
    .en        (timer_en),
    .count     (timer),
    .at_window (at_window)
  );

  assign timer_en = (state_q == StPreOpen) || (state_q == StPostOpen);

  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    close     = 1'b0;
    close_ltp = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Coincident spikes are ambiguous (dt=0) and open no window.
        if (pre_spike && !post_spike) begin
          state_d   = StPreOpen;
          timer_clr = 1'b1;
        end else if (post_spike && !pre_spike) begin
          state_d   = StPostOpen;
          timer_clr = 1'b1;
        end
      end
      StPreOpen: begin
        if (post_spike) begin
          state_d   = StUpdate;
          close     = 1'b1;
          close_ltp = 1'b1;
        end else if (pre_spike) begin
          timer_clr = 1'b1;
        end else if (at_window) begin
          state_d = StIdle;
        end
      end
      StPostOpen: begin
        if (pre_spike) begin
          state_d = StUpdate;
          close   = 1'b1;
        end else if (post_spike) begin
          timer_clr = 1'b1;
        end else if (at_window) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!learn_en) begin
      state_d   = StIdle;
      timer_clr = 1'b0;
      close     = 1'b0;
    end
  end

  assign do_update = (state_q == StUpdate) && learn_en;

  // Delta and clamp are computed one bit wider than the weight so nothing wraps.
  always_comb begin
    sh       = pend_dt_q >> TAU_SHIFT;
    amp      = pend_ltp_q ? APlusX : AMinusX;
    delta    = (32'(sh) >= W_WIDTH) ? '0 : (amp >> sh);
    sum      = {1'b0, weight_q} + delta;
    weight_d = weight_q;
    if (do_update) begin
      if (pend_ltp_q) begin
        weight_d = (sum > WMaxX) ? WMaxX[W_WIDTH-1:0] : sum[W_WIDTH-1:0];
      end else if ({1'b0, weight_q} < (delta + WMinX)) begin
        weight_d = WMinX[W_WIDTH-1:0];
      end else begin
        weight_d = weight_q - delta[W_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_dt_q  <= '0;
      pend_ltp_q <= 1'b0;
      weight_q   <= W_WIDTH'(W_INIT);
      syn_q      <= '0;
      valid_q    <= 1'b0;
      ltp_q      <= 1'b0;
      dt_q       <= '0;
    end else begin
      state_q  <= state_d;
      weight_q <= weight_d;
      syn_q    <= pre_spike ? weight_d : '0;
      valid_q  <= do_update;
      if (close) begin
        pend_dt_q  <= timer;
        pend_ltp_q <= close_ltp;
      end
      if (do_update) begin
        ltp_q <= pend_ltp_q;
        dt_q  <= pend_dt_q;
      end
    end
  end

  assign weight       = weight_q;
  assign syn_current  = syn_q;
  assign update_valid = valid_q;
  assign ltp          = ltp_q;
  assign dt           = dt_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_stdp_ctrl.sv
// Directed and random bench for stdp_ctrl against a timestamp-based pairing model.
module tb_stdp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       learn_en = 1'b1;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic [7:0] weight, syn_current;
  logic       update_valid, ltp, busy;
  logic [4:0] dt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: expected outputs plus open-window timestamp bookkeeping.
  int m_w = 64, m_syn = 0, m_uv = 0, m_ltp = 0, m_dt = 0, m_busy = 0;
  int open_kind = 0;  // 0 none, 1 pre opened, 2 post opened
  int open_cyc = 0;
  int pend = 0, pend_ltp = 0, pend_dt = 0;
  int cyc = 0;

  stdp_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .learn_en     (learn_en),
    .pre_spike    (pre_spike),
    .post_spike   (post_spike),
    .weight       (weight),
    .syn_current  (syn_current),
    .update_valid (update_valid),
    .ltp          (ltp),
    .dt           (dt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int delta_of(input int amp, input int d);
    int sh = d / 4;
    if (sh >= 8) return 0;
    return amp / (1 << sh);
  endfunction

  task automatic model(input bit p, input bit q, input bit l, input bit r);
    int k, d;
    bit closing, same;
    if (r) begin
      m_w = 64; m_syn = 0; m_uv = 0; m_ltp = 0; m_dt = 0;
      open_kind = 0; pend = 0;
    end else begin
      m_uv = 0;
      if (pend != 0) begin
        // Update cycle: spikes here are ignored.
        pend = 0;
        if (l) begin
          d = delta_of(32, pend_dt);
          if (pend_ltp != 0) m_w = (m_w + d > 255) ? 255 : m_w + d;
          else               m_w = (m_w - d < 0) ? 0 : m_w - d;
          m_uv = 1; m_ltp = pend_ltp; m_dt = pend_dt;
        end
      end else if (!l) begin
        open_kind = 0;
      end else if (open_kind == 0) begin
        if (p && !q) begin open_kind = 1; open_cyc = cyc; end
        else if (q && !p) begin open_kind = 2; open_cyc = cyc; end
      end else begin
        k = cyc - open_cyc;
        closing = (open_kind == 1) ? q : p;
        same    = (open_kind == 1) ? p : q;
        if (closing) begin
          pend = 1; pend_ltp = (open_kind == 1) ? 1 : 0; pend_dt = k; open_kind = 0;
        end else if (same) begin
          open_cyc = cyc;
        end else if (k >= 16) begin
          open_kind = 0;
        end
      end
      m_syn = p ? m_w : 0;
    end
    m_busy = (open_kind != 0 || pend != 0) ? 1 : 0;
    cyc++;
  endtask

  task automatic step(input bit p, input bit q, input bit l, input bit r);
    pre_spike = p; post_spike = q; learn_en = l; rst = r;
    @(posedge clk);
    #1;
    model(p, q, l, r);
    check("weight", 32'(weight), m_w);
    check("syn_current", 32'(syn_current), m_syn);
    check("update_valid", 32'(update_valid), m_uv);
    check("busy", 32'(busy), m_busy);
    check("ltp", 32'(ltp), m_ltp);
    check("dt", 32'(dt), m_dt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  // Opening spike, closing spike k cycles later, then let the update settle.
  task automatic pair(input bit pre_first, input int k);
    step(pre_first, !pre_first, 1, 0);
    idle(k - 1);
    step(!pre_first, pre_first, 1, 0);
    idle(3);
  endtask

  initial begin
    // Reset held two cycles with spikes toggling.
    step(1, 0, 1, 1);
    step(0, 1, 1, 1);
    check("t1_weight", 32'(weight), 64);
    idle(2);

    // LTP: pre at 0, post at 3.
    step(1, 0, 1, 0);
    idle(2);
    step(0, 1, 1, 0);
    idle(1);
    check("t2_valid", 32'(update_valid), 1);
    check("t2_weight", 32'(weight), 96);
    check("t2_busy", 32'(busy), 0);
    idle(2);

    // LTD: post at 0, pre at 9.
    step(0, 0, 1, 1);
    pair(1'b0, 9);
    check("t3_weight", 32'(weight), 56);

    // Window expiry, then late post opens a new window.
    step(0, 0, 1, 1);
    step(1, 0, 1, 0);
    idle(19);
    step(0, 1, 1, 0);
    check("t4_busy", 32'(busy), 1);
    check("t4_weight", 32'(weight), 64);
    idle(20);

    // Upper saturation.
    step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) pair(1'b1, 1);
    pair(1'b1, 5);
    check("t5_w240", 32'(weight), 240);
    pair(1'b1, 1);
    check("t5_sat_hi", 32'(weight), 255);

    // Lower saturation.
    step(0, 0, 1, 1);
    pair(1'b0, 1);
    pair(1'b0, 5);
    pair(1'b0, 13);
    pair(1'b0, 16);
    check("t5_w10", 32'(weight), 10);
    pair(1'b0, 1);
    check("t5_sat_lo", 32'(weight), 0);

    // Coincident spikes in IDLE.
    step(0, 0, 1, 1);
    step(1, 1, 1, 0);
    check("t6_coinc_busy", 32'(busy), 0);
    idle(3);

    // Reset aborts a pending pairing.
    step(1, 0, 1, 0);
    idle(1);
    step(0, 0, 1, 1);
    step(0, 1, 1, 0);
    idle(3);
    check("t6_abort_w", 32'(weight), 64);
    idle(20);

    // learn_en low freezes plasticity.
    step(1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0);
    idle(3);
    check("t6_learn_off", 32'(weight), 64);
    idle(20);

    // Synaptic current pulse.
    step(0, 0, 1, 1);
    pair(1'b1, 2);
    step(1, 0, 1, 0);
    check("t6_syn_on", 32'(syn_current), 96);
    step(0, 0, 1, 0);
    check("t6_syn_off", 32'(syn_current), 0);
    idle(20);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) != 0, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
